// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel programmable clock divider with shadowed divisors and single-step mode
module clk_div_multi #(
  parameter int NCH = 2,
  parameter int CNT_W = 24,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(24'h00ffff)
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             div_wr,
  input  logic [2:0]       div_ch,
  input  logic [CNT_W-1:0] div_val,
  input  logic             step_mode,
  input  logic             step_req,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   pending
);
  typedef enum logic [1:0] {RUN, STEP_IDLE, STEP_HIGH} state_t;
  logic [2:0] sync;
  logic step_pls;
  always_ff @(posedge clk_in or posedge reset)
    if (reset) sync <= '0;
    else sync <= {sync[1:0], step_req};
  assign step_pls = sync[1] & ~sync[2];
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t st, st_n;
    logic [CNT_W-1:0] cnt, cnt_n, term, term_n, shadow, shadow_n;
    logic co, co_n, tk, tk_n, pd, pd_n, wr, hit;
    assign wr = div_wr && div_ch == 3'(i);
    assign hit = cnt == term;
    // Terminal events apply the old shadow; a write in the same cycle stays pending.
    always_comb begin
      st_n = st;
      cnt_n = cnt + 1'b1;
      co_n = co;
      tk_n = 1'b0;
      term_n = term;
      shadow_n = wr ? div_val : shadow;
      pd_n = pd | wr;
      case (st)
        RUN:
          if (step_mode && !co) begin
            st_n = STEP_IDLE;
            cnt_n = '0;
          end else if (hit) begin
            cnt_n = '0;
            co_n = !co;
            tk_n = 1'b1;
            term_n = pd ? shadow : term;
            pd_n = wr;
            st_n = step_mode ? STEP_IDLE : RUN;
          end
        STEP_IDLE: begin
          cnt_n = '0;
          co_n = step_mode && step_pls;
          st_n = !step_mode ? RUN : step_pls ? STEP_HIGH : STEP_IDLE;
        end
        STEP_HIGH:
          if (hit) begin
            cnt_n = '0;
            co_n = 1'b0;
            tk_n = 1'b1;
            term_n = pd ? shadow : term;
            pd_n = wr;
            st_n = step_mode ? STEP_IDLE : RUN;
          end
        default: st_n = RUN;
      endcase
    end
    always_ff @(posedge clk_in or posedge reset)
      if (reset) begin
        st <= RUN;
        cnt <= '0;
        term <= DEF_DIV;
        shadow <= DEF_DIV;
        co <= 1'b0;
        tk <= 1'b0;
        pd <= 1'b0;
      end else begin
        st <= st_n;
        cnt <= cnt_n;
        term <= term_n;
        shadow <= shadow_n;
        co <= co_n;
        tk <= tk_n;
        pd <= pd_n;
      end
    assign clk_out[i] = co;
    assign tick[i] = tk;
    assign pending[i] = pd;
  end
endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 Parameter NCH, default 2: number of independent divider channels (1..8).
REQ-002 Parameter CNT_W, default 24: counter and divisor width in bits.
REQ-003 Parameter DEF_DIV, default 24'h00ffff: terminal count loaded into every channel at reset.
REQ-004 The block SHALL have port clk_in, input, 1 bit: source clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port div_wr, input, 1 bit: one-cycle strobe requesting a terminal-count update.
REQ-007 The block SHALL have port div_ch, input, 3 bits: target channel for div_wr.
REQ-008 The block SHALL have port div_val, input, CNT_W bits: new terminal count.
REQ-009 The block SHALL have port step_mode, input, 1 bit: 1 = single-step mode, 0 = free-run.
REQ-010 The block SHALL have port step_req, input, 1 bit: asynchronous pushbutton level requesting one output pulse.
REQ-011 The block SHALL have port clk_out, output, NCH bits: divided clock per channel.
REQ-012 The block SHALL have port tick, output, NCH bits: one-cycle pulse at each channel terminal event.
REQ-013 The block SHALL have port pending, output, NCH bits: 1 while a loaded divisor awaits application.

Function
REQ-014 Per channel, the block SHALL keep a counter cnt and an active terminal term, both CNT_W bits wide.
REQ-015 In RUN, on each rising edge of clk_in: if cnt==term, the block SHALL set cnt to 0, toggle clk_out and pulse tick; otherwise it SHALL increment cnt.
  - Output period = 2*(term+1) clk_in cycles, 50% duty.
  - term==0 yields divide-by-2.
REQ-016 On div_wr with div_ch<NCH, the block SHALL write div_val to that channel's shadow register and set its pending bit in the next cycle; div_wr with div_ch>=NCH SHALL be ignored.
REQ-017 A pending shadow SHALL be copied into term at the channel's next terminal event, and pending SHALL clear in the same cycle, so no runt phase occurs.
REQ-018 A div_wr to a channel whose pending bit is already set SHALL overwrite the shadow, with last write winning.
REQ-019 Before use, step_req SHALL pass through a 2-flop synchronizer followed by a rising-edge detector producing step_pls.
REQ-020 Each channel SHALL have a state machine with states RUN, STEP_IDLE and STEP_HIGH.
  - RUN -> STEP_IDLE when step_mode=1 and clk_out=0 (immediately), or at the terminal event that drives clk_out low if clk_out=1; the high phase is never truncated.
  - In STEP_IDLE: cnt=0, clk_out=0, tick=0.
  - STEP_IDLE -> STEP_HIGH on step_pls: clk_out=1 and cnt counts from 0.
  - STEP_HIGH -> STEP_IDLE at cnt==term: clk_out=0, tick pulses, cnt=0; the high phase lasts exactly term+1 cycles.
  - step_pls during STEP_HIGH SHALL be ignored, with no queuing.
  - STEP_IDLE -> RUN when step_mode=0, with cnt=0 and clk_out=0; STEP_HIGH completes first, then returns to RUN.
REQ-021 Pending divisor application SHALL also occur at the STEP_HIGH terminal event.
REQ-022 Channels SHALL be fully independent, except for the shared div_wr bus, step_mode and step_pls.

Reset
REQ-023 While reset=1, every channel SHALL hold cnt=0, term=DEF_DIV, shadow=DEF_DIV, clk_out=0, tick=0, pending=0 and state RUN, and the synchronizer and edge detector SHALL be cleared.
REQ-024 Reset asserted mid-operation SHALL abort any step pulse or pending load immediately and asynchronously, and the first terminal event after release SHALL occur DEF_DIV+1 cycles later.

Verification (CNT_W=8, DEF_DIV=3, NCH=2)
REQ-025 Release reset and free-run -> clk_out[0] and clk_out[1] toggle every 4 cycles (period 8), tick every 4 cycles, first tick 4 cycles after release.
REQ-026 div_wr ch1 val=1 mid-count -> pending[1]=1 until ch1's next terminal event; after that, clk_out[1] period is 4 and ch0 is unaffected.
REQ-027 Two div_wr to ch0 (val 5, then 0) before its terminal event -> term becomes 0 and ch0 divides by 2; div_ch=5 is ignored with no pending change.
REQ-028 step_mode=1 while clk_out=1 -> high phase completes, then clk_out stays low; one step_req press -> exactly one 4-cycle high pulse; a second press during the pulse produces no extra pulse.
REQ-029 step_mode returns to 0 -> free-run resumes from cnt=0 with clk_out low and first toggle after 4 cycles.
REQ-030 Reset asserted during STEP_HIGH with a pending load -> outputs low, pending=0, term=3 on release.
